// File: rtl/replay_credit_ctrl.sv
// Per-queue enqueue credit tracking with all-or-nothing issue and replay request.
// Credits are registered; the issue decision never sees same-cycle credit returns.
module replay_credit_ctrl #(
  parameter int unsigned NUM_Q = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   io_valid,
  input  logic [NUM_Q-1:0]       io_sigs_enq,
  input  logic [NUM_Q-1:0]       io_deq,
  output logic                   io_replay,
  output logic                   io_fire,
  output logic [NUM_Q-1:0]       io_enq,
  output logic [NUM_Q*CNT_W-1:0] io_credits,
  output logic [15:0]            io_replay_cnt,
  output logic                   io_err
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [CNT_W-1:0] credit [NUM_Q];
  logic [NUM_Q-1:0] ready;
  logic [NUM_Q-1:0] inc;
  logic [NUM_Q-1:0] dec;
  logic             blocked;
  logic             err_hit;
  logic [15:0]      replay_cnt;
  logic             err;

  always_comb begin
    ready = '0;
    for (int unsigned i = 0; i < NUM_Q; i++) begin
      ready[i] = (credit[i] != '0);
    end
  end

  always_comb begin
    blocked   = |(io_sigs_enq & ~ready);
    io_replay = io_valid & blocked;
    io_fire   = io_valid & ~blocked;
    io_enq    = {NUM_Q{io_fire}} & io_sigs_enq;
  end

  // Simultaneous enqueue and return on one queue cancel out.
  always_comb begin
    inc = io_deq & ~io_enq;
    dec = io_enq & ~io_deq;
  end

  always_comb begin
    err_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_Q; i++) begin
      if (inc[i] && (credit[i] == FULL)) begin
        err_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_Q; i++) begin
        credit[i] <= FULL;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_Q; i++) begin
        if (dec[i]) begin
          credit[i] <= credit[i] - CNT_W'(1);
        end else if (inc[i] && (credit[i] != FULL)) begin
          credit[i] <= credit[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      replay_cnt <= '0;
    end else if (io_replay && (replay_cnt != '1)) begin
      replay_cnt <= replay_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (err_hit) begin
      err <= 1'b1;
    end
  end

  always_comb begin
    io_credits = '0;
    for (int unsigned i = 0; i < NUM_Q; i++) begin
      io_credits[i*CNT_W +: CNT_W] = credit[i];
    end
  end

  assign io_replay_cnt = replay_cnt;
  assign io_err        = err;

endmodule

// File: doc/replay_credit_ctrl.md
Name: replay_credit_ctrl

Overview:
- Parametrised successor to the fixed two-queue decoder/replay logic.
- Tracks per-queue enqueue credits for NUM_Q downstream command queues.
- For each valid instruction, checks the decoded enqueue mask against the available credits and either fires it (strobing the required queues) or requests replay.
- Sits between the instruction decoder and the command/immediate queues of the issue stage.

Parameters:
- NUM_Q, 4, number of downstream queues (1..8)
- DEPTH, 4, capacity of each downstream queue in entries (1..255); credits reset to this value
- CNT_W, 3, credit counter width; must equal ceil(log2(DEPTH+1))

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- io_valid  in  1  decoded instruction present this cycle
- io_sigs_enq  in  NUM_Q  bit i set: instruction needs one entry in queue i
- io_deq  in  NUM_Q  bit i set: queue i freed one entry this cycle (credit return)
- io_replay  out  1  instruction must be replayed
- io_fire  out  1  instruction accepted
- io_enq  out  NUM_Q  enqueue strobe to queue i
- io_credits  out  NUM_Q*CNT_W  current credit per queue, queue i at bits [i*CNT_W +: CNT_W]
- io_replay_cnt  out  16  saturating count of replay cycles
- io_err  out  1  sticky: credit return arrived on a full-credit queue

Behaviour:
- Reset (async, immediate on assertion):
  - every credit = DEPTH
  - io_replay_cnt = 0, io_err = 0
  - combinational outputs follow from these values: io_replay=0; io_fire=io_valid; io_enq=io_sigs_enq gated by io_valid
- ready_i = (credit_i != 0), computed from the registered credit only; no same-cycle bypass of io_deq.
- Issue decision is combinational, zero latency:
  - io_replay = io_valid & OR_i(io_sigs_enq[i] & ~ready_i)
  - io_fire = io_valid & ~io_replay
  - io_enq[i] = io_fire & io_sigs_enq[i]
- All-or-nothing: no queue is strobed unless every required queue has credit.
- Valid with an all-zero io_sigs_enq: fires, no enqueue strobes.
- Credit update per queue, each clock edge:
  - io_enq=1, io_deq=0: credit - 1
  - io_enq=0, io_deq=1: credit + 1
  - both set: unchanged
  - neither set: unchanged
- Boundaries:
  - Enqueue at credit 0 cannot occur by construction.
  - io_deq at credit == DEPTH with no same-cycle io_enq: credit stays DEPTH and io_err is set. io_err clears only on reset.
  - io_deq at credit 0: credit becomes 1 next cycle. An instruction needing that queue in the same cycle still replays (no bypass).
- io_replay_cnt increments by 1 on each cycle io_replay=1 and saturates at 0xFFFF with no wrap.
- Replay is re-evaluated every cycle. The upstream re-presents the instruction; the block holds no instruction state.
- Reset asserted mid-operation: all credits return to DEPTH immediately, regardless of outstanding entries.
- CNT_W arithmetic is unsigned. No overflow is possible given the saturation rules above.

Test Plan:
- Reset, then io_valid=1, io_sigs_enq=4'b0101 -> io_fire=1, io_enq=4'b0101, io_replay=0; next cycle credits = {4,3,4,3} (q3..q0).
- Four consecutive fires to queue 0, then a fifth -> fifth cycle io_replay=1, io_enq=0, credit0=0, io_replay_cnt=1.
- credit0=0, io_deq[0]=1 with the instruction needing q0 in the same cycle -> io_replay=1 that cycle; next cycle io_fire=1, credit0 returns to 0.
- credit1=2, io_enq[1] and io_deq[1] in the same cycle -> credit1 stays 2.
- From reset, io_deq[2]=1 -> credit2 stays 4, io_err=1 and remains 1 until reset.
- Hold a replay for 70000 cycles -> io_replay_cnt=0xFFFF. Assert reset mid-run -> all credits=4 and io_replay_cnt=0 asynchronously.
